tdm_demux4: RTL

- Receive-side counterpart of the team's 4:1 select mux, which transmits four single-bit channels time-division multiplexed onto one wire (select rotating 0,1,2,3).
- Takes the serial slot stream plus a frame-sync marker, locks to slot 0 and routes each slot bit to its channel.
- Assembles DATA_W-bit words per channel and presents all four words together once per multiframe.
- Sits between the TDM link and the per-channel consumers.

---
 rtl/tdm_pkg.sv | 10 +
 rtl/tdm_ch_shreg.sv | 34 +++
 rtl/tdm_demux4.sv | 114 +++++++++++
 3 files changed

// File: rtl/tdm_pkg.sv
// Shared constants and FSM state encoding for the 4-channel TDM receive path.
package tdm_pkg;
    localparam int NUM_CH = 4;
    localparam int SLOT_W = 2;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_e;
endpackage

// File: rtl/tdm_ch_shreg.sv
// Per-channel word assembler: writes one serial bit into an indexed position.
module tdm_ch_shreg #(
    parameter int DATA_W = 8,
    parameter int IDX_W  = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clr,
    input  logic [IDX_W-1:0]  idx,
    input  logic              din,
    output logic [DATA_W-1:0] word
);
    logic [DATA_W-1:0] word_q;
    logic [DATA_W-1:0] word_d;

    // Clear and write may coincide: the write lands on the cleared word.
    always_comb begin
        word_d = clr ? '0 : word_q;
        if (en) begin
            word_d[idx] = din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word_q <= '0;
        end else begin
            word_q <= word_d;
        end
    end

    assign word = word_q;
endmodule

// File: rtl/tdm_demux4.sv
// TDM receiver: locks to the frame-sync marker, routes slot bits to four channel
// words and presents all four together once per multiframe.
// Handshake: a beat is any cycle with DEMUX_in_valid=1; other cycles hold all state.
module tdm_demux4
    import tdm_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       DEMUX_in,
    input  logic                       DEMUX_in_valid,
    input  logic                       DEMUX_sync,
    output logic [NUM_CH*DATA_W-1:0]   DEMUX_out,
    output logic                       DEMUX_out_valid,
    output logic [SLOT_W-1:0]          DEMUX_sel,
    output logic                       locked,
    output logic                       sync_err
);
    localparam int                BCW       = $clog2(DATA_W);
    localparam logic [BCW-1:0]    LAST_BIT  = BCW'(DATA_W - 1);
    localparam logic [BCW-1:0]    BIT_ONE   = BCW'(1);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_CH - 1);
    localparam logic [SLOT_W-1:0] SLOT_ONE  = SLOT_W'(1);

    state_e                   state_q, state_d;
    logic [SLOT_W-1:0]        slot_q, slot_d;
    logic [BCW-1:0]           bit_cnt_q, bit_cnt_d;
    logic [NUM_CH*DATA_W-1:0] out_q, out_d;
    logic                     out_valid_q, out_valid_d;
    logic                     sync_err_q, sync_err_d;

    logic [NUM_CH-1:0]        wr_en;
    logic                     wr_clr;
    logic [BCW-1:0]           wr_idx;
    logic [DATA_W-1:0]        ch_word [NUM_CH];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        tdm_ch_shreg #(.DATA_W(DATA_W), .IDX_W(BCW)) u_shreg (
            .clk  (clk),
            .rst  (rst),
            .en   (wr_en[g]),
            .clr  (wr_clr),
            .idx  (wr_idx),
            .din  (DEMUX_in),
            .word (ch_word[g])
        );
    end

    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        bit_cnt_d   = bit_cnt_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        sync_err_d  = 1'b0;
        wr_en       = '0;
        wr_clr      = 1'b0;
        wr_idx      = bit_cnt_q;

        if (DEMUX_in_valid) begin
            if (state_q == HUNT || (DEMUX_sync && slot_q != '0)) begin
                // (Re)start a multiframe on this beat as ch0 bit 0.
                if (DEMUX_sync) begin
                    sync_err_d = (state_q == LOCKED);
                    state_d    = LOCKED;
                    wr_clr     = 1'b1;
                    wr_en[0]   = 1'b1;
                    wr_idx     = '0;
                    slot_d     = SLOT_ONE;
                    bit_cnt_d  = '0;
                end
            end else begin
                wr_en[slot_q] = 1'b1;
                slot_d        = slot_q + SLOT_ONE;
                if (slot_q == LAST_SLOT) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        // The final bit is still in flight; splice it into ch3's MSB.
                        bit_cnt_d   = '0;
                        out_valid_d = 1'b1;
                        out_d       = {DEMUX_in, ch_word[3][DATA_W-2:0],
                                       ch_word[2], ch_word[1], ch_word[0]};
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_ONE;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= HUNT;
            slot_q      <= '0;
            bit_cnt_q   <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            sync_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            bit_cnt_q   <= bit_cnt_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            sync_err_q  <= sync_err_d;
        end
    end

    assign DEMUX_out       = out_q;
    assign DEMUX_out_valid = out_valid_q;
    assign DEMUX_sel       = slot_q;
    assign locked          = (state_q == LOCKED);
    assign sync_err        = sync_err_q;
endmodule
